// File: rtl/adder.sv
// Registered WIDTH-bit adder with carry-in/carry-out, built from 4-bit
// carry-lookahead groups whose group carries ripple from one group to the next.
module adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oValid
);

  localparam int unsigned GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] sumNext;
  logic             carryNext;

  // One lookahead group: returns {groupCarryOut, sum[3:0]}.
  function automatic logic [4:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cin
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       grpG;
    logic       grpP;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grpG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grpP = &p;
    return {grpG | (grpP & cin), p ^ c};
  endfunction

  always_comb begin
    logic [GROUPS:0] grpCarry;
    logic [4:0]      grpOut;
    sumNext     = '0;
    grpCarry    = '0;
    grpOut      = '0;
    grpCarry[0] = iC;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      grpOut          = cla4(iData_a[4*k +: 4], iData_b[4*k +: 4], grpCarry[k]);
      sumNext[4*k +: 4] = grpOut[3:0];
      grpCarry[k+1]   = grpOut[4];
    end
    carryNext = grpCarry[GROUPS];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oData   <= '0;
      oData_C <= 1'b0;
      oValid  <= 1'b0;
    end else begin
      oValid <= iEn;
      if (iEn) begin
        oData   <= sumNext;
        oData_C <= carryNext;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder (WIDTH=8): directed cases, then randomized
// traffic against a plain-arithmetic reference with hold and reset behaviour.
module tb_adder;

  localparam int unsigned W = 8;

  logic         iClk;
  logic         iRst;
  logic         iEn;
  logic [W-1:0] iData_a;
  logic [W-1:0] iData_b;
  logic         iC;
  logic [W-1:0] oData;
  logic         oData_C;
  logic         oValid;

  int unsigned nVec;
  int unsigned nErr;

  // Reference state: what the output registers should hold.
  logic [W-1:0] mData;
  logic         mCarry;
  logic         mValid;

  adder #(.WIDTH(W)) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iEn     (iEn),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iC      (iC),
    .oData   (oData),
    .oData_C (oData_C),
    .oValid  (oValid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chkAll(input string tag, input logic [W-1:0] d, input logic c, input logic v);
    chk({tag, ".data"},  32'(oData),   32'(d));
    chk({tag, ".carry"}, 32'(oData_C), 32'(c));
    chk({tag, ".valid"}, 32'(oValid),  32'(v));
  endtask

  // Drive operands at the falling edge, pass through one rising edge,
  // and update the reference model with integer arithmetic.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic en, input logic rst);
    int unsigned total;
    @(negedge iClk);
    iData_a = a;
    iData_b = b;
    iC      = c;
    iEn     = en;
    iRst    = rst;
    if (rst) begin
      mData = '0; mCarry = 1'b0; mValid = 1'b0;
      #1 chkAll("asyncRst", mData, mCarry, mValid);
    end
    @(posedge iClk);
    if (rst) begin
      mData = '0; mCarry = 1'b0; mValid = 1'b0;
    end else if (en) begin
      total  = int'(a) + int'(b) + int'(c);
      mData  = W'(total % (1 << W));
      mCarry = (total >= (1 << W));
      mValid = 1'b1;
    end else begin
      mValid = 1'b0;
    end
    #1;
  endtask

  initial begin
    nVec = 0; nErr = 0;
    mData = '0; mCarry = 1'b0; mValid = 1'b0;
    iRst = 1'b1; iEn = 1'b0; iData_a = '0; iData_b = '0; iC = 1'b0;
    repeat (2) @(posedge iClk);

    // Load a nonzero result, then assert reset between edges.
    step(8'h55, 8'h11, 1'b0, 1'b1, 1'b0);
    chkAll("preload", 8'h66, 1'b0, 1'b1);
    @(negedge iClk);
    iData_a = W'($urandom); iData_b = W'($urandom); iC = 1'($urandom); iEn = 1'b1;
    #2 iRst = 1'b1;
    #1 chkAll("rstNoClk", 8'h00, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chkAll("rstRelease", 8'h00, 1'b0, 1'b0);

    step(8'h00, 8'h01, 1'b1, 1'b1, 1'b0); chkAll("small",   8'h02, 1'b0, 1'b1);
    step(8'hC0, 8'hC1, 1'b1, 1'b1, 1'b0); chkAll("carryOut", 8'h82, 1'b1, 1'b1);
    step(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0); chkAll("maxVal",   8'hFF, 1'b1, 1'b1);
    step(8'hFC, 8'hFC, 1'b0, 1'b1, 1'b0); chkAll("b2bFirst", 8'hF8, 1'b1, 1'b1);
    step(8'h4F, 8'hFA, 1'b1, 1'b1, 1'b0); chkAll("b2bSecond", 8'h4A, 1'b1, 1'b1);
    step(8'h0F, 8'h00, 1'b1, 1'b1, 1'b0); chkAll("grpCarry", 8'h10, 1'b0, 1'b1);
    step(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0); chkAll("ripple",   8'h00, 1'b1, 1'b1);
    step(8'h12, 8'h34, 1'b1, 1'b0, 1'b0); chkAll("hold",     8'h00, 1'b1, 1'b0);

    // Sync model with the hold state reached by the directed section.
    mData = 8'h00; mCarry = 1'b1; mValid = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      logic rst;
      logic en;
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      step(W'($urandom), W'($urandom), 1'($urandom), en, rst);
      chkAll("rand", mData, mCarry, mValid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder.md
# adder

Registered WIDTH-bit binary adder with carry-in and carry-out, default 8 bits. It forms {oData_C, oData} = iData_a + iData_b + iC and presents the result from a register one clock after the operands are accepted. It is the arithmetic leaf used by datapath blocks that need a pipelined add with an explicit carry chain.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are multiples of 4, minimum 4.

Ports:
- One clock; reset is asynchronous and active-high.
- iClk  input  1  clock; all state updates on its rising edge.
- iRst  input  1  asynchronous active-high reset.
- iEn  input  1  operand-valid strobe; operands are captured on a rising edge where iEn=1.
- iData_a  input  WIDTH  addend A, unsigned.
- iData_b  input  WIDTH  addend B, unsigned.
- iC  input  1  carry-in, weight 1.
- oData  output  WIDTH  registered sum, bits [WIDTH-1:0].
- oData_C  output  1  registered carry-out, weight 2^WIDTH.
- oValid  output  1  high for one cycle when oData/oData_C hold a newly computed result.

## Operation

- Arithmetic: the (WIDTH+1)-bit unsigned result {oData_C, oData} equals iData_a + iData_b + iC.
- No overflow exists: the maximum input, all-ones + all-ones + 1, gives 2^(WIDTH+1) − 1 and fits in WIDTH+1 bits.
- Signed interpretation is the user's concern. No overflow flag is produced.
- Carry structure:
  - The sum logic is built from 4-bit carry-lookahead groups, with per-bit generate g=a&b, propagate p=a^b and sum s=p^c.
  - Each group produces a group generate and group propagate. The carry rippling between groups is the group carry-out.
  - Carry-in of group 0 is iC. oData_C is the carry-out of the top group.
- Capture:
  - On a rising edge with iEn=1, the computed sum and carry load into the output registers and oValid is set to 1.
  - On a rising edge with iEn=0, oData and oData_C hold their previous values and oValid is cleared to 0.
- Reset:
  - While iRst=1, independent of iClk, oData=0, oData_C=0 and oValid=0.
  - Reset asserted mid-operation discards any pending result.
  - The first capture after reset is the first edge where iRst=0 and iEn=1.
- Inputs may change every cycle. Back-to-back iEn=1 gives one result per cycle.

## Timing

- Latency: one cycle. Operands sampled at edge N appear on oData/oData_C/oValid immediately after edge N.
- Throughput: one add per clock.
- All outputs come directly from flops. There is no combinational path from any input to any output.
- Input-to-register path: one 4-bit lookahead per group plus an inter-group ripple. This must close at the target clock for WIDTH=8.
- Deassertion of iRst is assumed synchronous to iClk by the surrounding design. The reset flops themselves use asynchronous assertion.

## Test plan

Each line applies the operands with iEn=1 for one edge and checks the registered outputs after that edge (WIDTH=8):
- Reset: assert iRst with random inputs and iEn=1 -> oData=0x00, oData_C=0, oValid=0 immediately, with no clock needed. Release reset, then drive iEn=0 for one edge -> outputs stay 0.
- a=0x00, b=0x01, iC=1 -> oData=0x02, oData_C=0, oValid=1.
- a=0xC0, b=0xC1, iC=1 -> oData=0x82, oData_C=1. Then a=0xFF, b=0xFF, iC=1 -> oData=0xFF, oData_C=1 (maximum-value case).
- a=0xFC, b=0xFC, iC=0 -> oData=0xF8, oData_C=1. Then a=0x4F, b=0xFA, iC=1 -> oData=0x4A, oData_C=1. Run the two back-to-back; the second result must appear exactly one cycle after the first.
- Carry propagation: a=0x0F, b=0x00, iC=1 -> oData=0x10, oData_C=0 (inter-group carry). Then a=0xFF, b=0x00, iC=1 -> oData=0x00, oData_C=1 (full ripple). Then drop iEn -> oData holds 0x00 and oValid=0.
- Random: 10,000 random a, b, iC with random iEn and occasional mid-stream iRst pulses. Compare against a reference model of a+b+c with one-cycle delay, including hold on iEn=0 and clear on iRst.
